exc_sequencer: RTL and testbench

//  Exception/interrupt entry-and-return sequencer sitting between the pipeline (M stage) and CP0.

---
 rtl/exc_sequencer.sv | 145 ++++++++++++++
 tb/tb_exc_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_sequencer.sv
// Exception/interrupt entry-and-return sequencer between the M stage and CP0.
// Synchronises the external interrupt lines, arbitrates exception > interrupt > eret, then flushes.
module exc_sequencer #(
   parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
   parameter int          SYNC_STAGES  = 2,
   parameter logic [5:0]  EDGE_MASK    = 6'b000000,
   parameter int          FLUSH_CYCLES = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  hw_irq,
   input  logic [5:0]  irq_clr,
   input  logic [5:0]  sr_im,
   input  logic        sr_ie,
   input  logic        sr_exl,
   input  logic [31:0] epc_in,
   input  logic        m_valid,
   input  logic [31:0] m_pc,
   input  logic        m_bd,
   input  logic        m_exc,
   input  logic [4:0]  m_exc_code,
   input  logic        m_eret,
   output logic [5:0]  hwint,
   output logic        cp0_take,
   output logic [5:0]  cp0_exc_code,
   output logic [31:0] cp0_pc,
   output logic        cp0_bd,
   output logic        cp0_exlclr,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic        busy
);
   localparam int CW = $clog2(FLUSH_CYCLES) + 1;

   typedef enum logic [1:0] {IDLE, ENTER, ERET, FLUSH} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [5:0]    cap_code, cap_code_n;
   logic [31:0]   cap_pc, cap_pc_n;
   logic          cap_bd, cap_bd_n;

   logic [5:0]    sync_q [SYNC_STAGES];
   logic [5:0]    s, s_d, pend, rise;
   logic          int_ok;

   assign s     = sync_q[SYNC_STAGES-1];
   assign rise  = s & ~s_d;
   assign hwint = pend;

   // Edge lines: a fresh rising edge beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         s_d  <= '0;
         pend <= '0;
      end else begin
         sync_q[0] <= hw_irq;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         s_d  <= s;
         pend <= (EDGE_MASK & (rise | (pend & ~irq_clr))) | (~EDGE_MASK & s);
      end
   end

   assign int_ok = (|(pend & sr_im)) & sr_ie & ~sr_exl;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         cap_code <= '0;
         cap_pc   <= '0;
         cap_bd   <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         cap_code <= cap_code_n;
         cap_pc   <= cap_pc_n;
         cap_bd   <= cap_bd_n;
      end
   end

   always_comb begin
      state_n        = state;
      cnt_n          = cnt;
      cap_code_n     = cap_code;
      cap_pc_n       = cap_pc;
      cap_bd_n       = cap_bd;
      cp0_take       = 1'b0;
      cp0_exc_code   = '0;
      cp0_pc         = '0;
      cp0_bd         = 1'b0;
      cp0_exlclr     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      flush          = 1'b0;
      busy           = (state != IDLE);
      case (state)
         IDLE: begin
            // A bubble in M never takes an interrupt; it waits for a real instruction.
            if (m_valid) begin
               if (m_exc) begin
                  cap_code_n = {1'b1, m_exc_code};
                  cap_pc_n   = m_pc;
                  cap_bd_n   = m_bd;
                  state_n    = ENTER;
               end else if (int_ok) begin
                  cap_code_n = 6'd0;
                  cap_pc_n   = m_pc;
                  cap_bd_n   = m_bd;
                  state_n    = ENTER;
               end else if (m_eret) begin
                  state_n    = ERET;
               end
            end
         end
         ENTER: begin
            cp0_take       = 1'b1;
            cp0_exc_code   = cap_code;
            cp0_pc         = cap_pc;
            cp0_bd         = cap_bd;
            redirect_valid = 1'b1;
            redirect_pc    = HANDLER_PC;
            flush          = 1'b1;
            cnt_n          = CW'(FLUSH_CYCLES - 1);
            state_n        = FLUSH;
         end
         ERET: begin
            cp0_exlclr     = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = epc_in;
            flush          = 1'b1;
            cnt_n          = CW'(FLUSH_CYCLES - 1);
            state_n        = FLUSH;
         end
         FLUSH: begin
            flush = 1'b1;
            if (cnt == '0) state_n = IDLE;
            else           cnt_n   = cnt - CW'(1);
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: reset, directed vector table, hand sequences, and a randomized run
// compared every cycle against a cycle-count reference model.
module tb_exc_sequencer;
   localparam logic [31:0] HPC = 32'h0000_4180;
   localparam int          SS  = 2;
   localparam logic [5:0]  EM  = 6'h01;
   localparam int          FC  = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  hw_irq, irq_clr, sr_im;
   logic        sr_ie, sr_exl, m_valid, m_bd, m_exc, m_eret;
   logic [31:0] epc_in, m_pc;
   logic [4:0]  m_exc_code;
   logic [5:0]  hwint, cp0_exc_code;
   logic        cp0_take, cp0_bd, cp0_exlclr, redirect_valid, flush, busy;
   logic [31:0] cp0_pc, redirect_pc;

   exc_sequencer #(.HANDLER_PC(HPC), .SYNC_STAGES(SS), .EDGE_MASK(EM), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .reset(reset), .hw_irq(hw_irq), .irq_clr(irq_clr), .sr_im(sr_im),
      .sr_ie(sr_ie), .sr_exl(sr_exl), .epc_in(epc_in), .m_valid(m_valid), .m_pc(m_pc),
      .m_bd(m_bd), .m_exc(m_exc), .m_exc_code(m_exc_code), .m_eret(m_eret),
      .hwint(hwint), .cp0_take(cp0_take), .cp0_exc_code(cp0_exc_code), .cp0_pc(cp0_pc),
      .cp0_bd(cp0_bd), .cp0_exlclr(cp0_exlclr), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .flush(flush), .busy(busy));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: raw-line history, pending vector, remaining flush cycles, current action.
   logic [5:0]  mq[$];
   logic [5:0]  m_pend;
   int          m_left;
   int          m_act;   // 0 none, 1 take, 2 eret
   logic [5:0]  m_code;
   logic [31:0] m_cpc;
   logic        m_cbd;

   task automatic model_clear();
      mq = {};
      for (int i = 0; i <= SS; i++) mq.push_back(6'h00);
      m_pend = '0; m_left = 0; m_act = 0; m_code = '0; m_cpc = '0; m_cbd = 1'b0;
   endtask

   task automatic model_edge();
      logic [5:0] s_pre, sd_pre;
      bit         ok;
      if (!reset) begin
         model_clear();
         return;
      end
      s_pre  = mq[SS-1];
      sd_pre = mq[SS];
      ok     = ((m_pend & sr_im) != 6'h00) && sr_ie && !sr_exl;
      m_pend = (EM & ((s_pre & ~sd_pre) | (m_pend & ~irq_clr))) | (~EM & s_pre);
      mq.push_front(hw_irq);
      void'(mq.pop_back());
      if (m_left == 0) begin
         m_act = 0;
         if (m_valid) begin
            if (m_exc) begin
               m_act = 1; m_code = {1'b1, m_exc_code}; m_cpc = m_pc; m_cbd = m_bd;
            end else if (ok) begin
               m_act = 1; m_code = 6'h00; m_cpc = m_pc; m_cbd = m_bd;
            end else if (m_eret) begin
               m_act = 2;
            end
         end
         if (m_act != 0) m_left = FC + 1;
      end else begin
         m_left--;
         m_act = 0;
      end
   endtask

   function automatic logic [81:0] model_out();
      logic take, eret;
      take = (m_act == 1);
      eret = (m_act == 2);
      return {m_pend, take, take ? m_code : 6'h00, take ? m_cpc : 32'h0, take & m_cbd,
              eret, take | eret, take ? HPC : (eret ? epc_in : 32'h0),
              m_left > 0, m_left > 0};
   endfunction

   function automatic logic [81:0] dut_out();
      return {hwint, cp0_take, cp0_exc_code, cp0_pc, cp0_bd, cp0_exlclr, redirect_valid,
              redirect_pc, flush, busy};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cycle();
      logic [81:0] a, e;
      @(posedge clk);
      model_edge();
      #1;
      a = dut_out();
      e = model_out();
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL model t=%0t: got %h expected %h", $time, a, e);
      end
   endtask

   typedef struct {
      logic [5:0]  hw;
      logic [5:0]  im;
      logic        ie, exl, mv, me, er, bd;
      logic [4:0]  code;
      logic [31:0] pc;
      logic        e_take, e_exlclr;
      logic [5:0]  e_code;
      logic [31:0] e_rpc, e_cpc;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int flush_cnt;
      //               hw    im    ie   exl  mv   me   er   bd   code   pc           take exlc code   rpc          cpc
      vecs[0] = '{6'h00, 6'h00, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,5'd4, 32'h3008, 1'b1,1'b0,6'h24,32'h4180,32'h3008};
      vecs[1] = '{6'h04, 6'h04, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h3100, 1'b1,1'b0,6'h00,32'h4180,32'h3100};
      vecs[2] = '{6'h04, 6'h04, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h3100, 1'b0,1'b0,6'h00,32'h0,   32'h0};
      vecs[3] = '{6'h04, 6'h00, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h3100, 1'b0,1'b0,6'h00,32'h0,   32'h0};
      vecs[4] = '{6'h04, 6'h04, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h3100, 1'b0,1'b0,6'h00,32'h0,   32'h0};
      vecs[5] = '{6'h00, 6'h00, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h3200, 1'b0,1'b1,6'h00,32'h3010,32'h0};
      vecs[6] = '{6'h04, 6'h04, 1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,5'd12,32'h3300, 1'b1,1'b0,6'h2C,32'h4180,32'h3300};
      vecs[7] = '{6'h08, 6'h08, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,5'd0, 32'h3404, 1'b1,1'b0,6'h00,32'h4180,32'h3404};
      vecs[8] = '{6'h00, 6'h00, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,5'd4, 32'h3500, 1'b0,1'b0,6'h00,32'h0,   32'h0};
      vecs[9] = '{6'h00, 6'h00, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,5'd31,32'h3600, 1'b1,1'b0,6'h3F,32'h4180,32'h3600};

      reset = 1'b0; hw_irq = 6'h3F; irq_clr = '0; sr_im = '0; sr_ie = 1'b0; sr_exl = 1'b0;
      epc_in = 32'h3010; m_valid = 1'b0; m_pc = '0; m_bd = 1'b0; m_exc = 1'b0;
      m_exc_code = '0; m_eret = 1'b0;
      model_clear();

      // Reset with all lines high, then release and watch hwint fill.
      repeat (3) cycle();
      chk("reset_outputs_zero", 32'(|dut_out()), 32'h0);
      reset = 1'b1;
      cycle(); cycle();
      chk("hwint_before_sync", 32'(hwint), 32'h00);
      cycle();
      chk("hwint_after_sync", 32'(hwint), 32'h3F);

      // Directed vector table.
      for (int i = 0; i < 10; i++) begin
         irq_clr = 6'h3F; hw_irq = vecs[i].hw; sr_im = vecs[i].im; sr_ie = vecs[i].ie;
         sr_exl = vecs[i].exl; m_valid = 1'b0; m_exc = 1'b0; m_eret = 1'b0;
         cycle();
         irq_clr = '0;
         repeat (5) cycle();
         m_valid = vecs[i].mv; m_exc = vecs[i].me; m_eret = vecs[i].er;
         m_exc_code = vecs[i].code; m_pc = vecs[i].pc; m_bd = vecs[i].bd;
         cycle();
         m_valid = 1'b0; m_exc = 1'b0; m_eret = 1'b0;
         chk($sformatf("vec%0d_take", i),   32'(cp0_take),     32'(vecs[i].e_take));
         chk($sformatf("vec%0d_exlclr", i), 32'(cp0_exlclr),   32'(vecs[i].e_exlclr));
         chk($sformatf("vec%0d_code", i),   32'(cp0_exc_code), 32'(vecs[i].e_code));
         chk($sformatf("vec%0d_rpc", i),    redirect_pc,       vecs[i].e_rpc);
         chk($sformatf("vec%0d_cpc", i),    cp0_pc,            vecs[i].e_cpc);
         hw_irq = '0; sr_ie = 1'b0;
         repeat (8) cycle();
      end

      // Exception entry: flush length and busy release.
      m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd4; m_pc = 32'h3008; m_bd = 1'b1;
      cycle();
      m_valid = 1'b0; m_exc = 1'b0;
      chk("exc_bd", 32'(cp0_bd), 32'h1);
      flush_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         if (flush) flush_cnt++;
         cycle();
      end
      chk("exc_flush_len", 32'(flush_cnt), 32'd4);
      chk("exc_busy_after", 32'(busy), 32'h0);

      // Priority: exception wins, interrupt follows on first IDLE cycle.
      hw_irq = 6'h04; sr_im = 6'h04; sr_ie = 1'b1; sr_exl = 1'b0;
      repeat (5) cycle();
      m_valid = 1'b1; m_exc = 1'b1; m_eret = 1'b1; m_exc_code = 5'd10; m_pc = 32'h3700;
      cycle();
      chk("prio_exc_first", 32'(cp0_exc_code), 32'h2A);
      m_exc = 1'b0; m_eret = 1'b0; m_pc = 32'h3710;
      repeat (4) cycle();
      chk("prio_int_not_yet", 32'(cp0_take), 32'h0);
      cycle();
      chk("prio_int_take", 32'(cp0_take), 32'h1);
      chk("prio_int_code", 32'(cp0_exc_code), 32'h00);
      m_valid = 1'b0;
      repeat (6) cycle();

      // Masking by EXL, then EXL cleared with a valid M instruction.
      sr_exl = 1'b1; m_valid = 1'b1;
      repeat (6) begin
         cycle();
         chk("mask_exl_no_take", 32'(busy), 32'h0);
      end
      sr_exl = 1'b0;
      cycle();
      chk("unmask_take", 32'(cp0_take), 32'h1);
      m_valid = 1'b0; hw_irq = '0; sr_ie = 1'b0;
      repeat (8) cycle();

      // Edge-latched line 0.
      hw_irq = 6'h01; cycle(); hw_irq = 6'h00;
      repeat (4) cycle();
      chk("edge_latched", 32'(hwint[0]), 32'h1);
      repeat (4) cycle();
      chk("edge_held", 32'(hwint[0]), 32'h1);
      hw_irq = 6'h01; cycle(); hw_irq = 6'h00; cycle();
      irq_clr = 6'h01; cycle(); irq_clr = 6'h00;
      chk("edge_set_beats_clr", 32'(hwint[0]), 32'h1);
      irq_clr = 6'h01; cycle(); irq_clr = 6'h00;
      chk("edge_cleared", 32'(hwint[0]), 32'h0);
      cycle();

      // Eret, discarded exception during FLUSH, reset mid-FLUSH.
      epc_in = 32'h3010; m_valid = 1'b1; m_eret = 1'b1;
      cycle();
      m_eret = 1'b0;
      chk("eret_exlclr", 32'(cp0_exlclr), 32'h1);
      chk("eret_rpc", redirect_pc, 32'h3010);
      m_exc = 1'b1; m_exc_code = 5'd8;
      cycle();
      chk("eret_flush_exc_ignored", 32'(cp0_take), 32'h0);
      chk("eret_flush_on", 32'(flush), 32'h1);
      reset = 1'b0;
      cycle();
      chk("reset_mid_flush", 32'(flush), 32'h0);
      chk("reset_mid_busy", 32'(busy), 32'h0);
      m_valid = 1'b0; m_exc = 1'b0; reset = 1'b1;
      repeat (4) cycle();

      // Randomized run against the model.
      for (int k = 0; k < 3000; k++) begin
         for (int b = 0; b < 6; b++)
            if ($urandom_range(0, 15) == 0) hw_irq[b] = ~hw_irq[b];
         irq_clr    = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'h00;
         sr_im      = 6'($urandom_range(0, 63));
         sr_ie      = ($urandom_range(0, 3) != 0);
         sr_exl     = ($urandom_range(0, 3) == 0);
         epc_in     = $urandom;
         m_valid    = ($urandom_range(0, 3) != 0);
         m_pc       = $urandom;
         m_bd       = 1'($urandom_range(0, 1));
         m_exc      = ($urandom_range(0, 7) == 0);
         m_exc_code = 5'($urandom_range(0, 31));
         m_eret     = ($urandom_range(0, 7) == 0);
         reset      = ($urandom_range(0, 199) != 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
